// File: rtl/smartbench_pkg.sv
// Shared definitions for the SmartBench host-command path: receive-decoder
// state encoding, frame header layout and the command codes understood by
// the oscilloscope core.
package smartbench_pkg;

    // Receive decoder states. WRITE lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        WRITE    = 2'd2
    } rx_state_t;

    // Header byte layout: bit 7 selects command (1) or register write (0).
    // The low seven bits carry the command code or register address.
    localparam int HDR_CMD_BIT    = 7;
    localparam int REG_ADDR_WIDTH = 7;

    // Single-byte command codes for the scope core.
    localparam logic [REG_ADDR_WIDTH-1:0] CMD_RESET    = 7'h00;
    localparam logic [REG_ADDR_WIDTH-1:0] CMD_START    = 7'h01;
    localparam logic [REG_ADDR_WIDTH-1:0] CMD_STOP     = 7'h02;
    localparam logic [REG_ADDR_WIDTH-1:0] CMD_REQ_DATA = 7'h03;

    // True when a header byte announces a single-byte command.
    function automatic logic is_cmd_header(input logic [7:0] hdr);
        return hdr[HDR_CMD_BIT];
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte timeout counter. Counts cycles while enabled, saturating at
// TIMEOUT_CYCLES-1; expire is high whenever it sits at that value while
// enabled. A clear returns it to zero and takes priority over counting.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Cycle counter: cleared on request, otherwise advances and saturates at LAST.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its neighbours, independent of order.
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Frames the FT245 receive byte stream into register writes and single-byte
// commands for the oscilloscope control logic.
//   header[7]=1 : command, code = header[6:0], strobed on cmd_strobe.
//   header[7]=0 : register write, addr = header[6:0], followed by
//                 DATA_WIDTH/8 little-endian payload bytes, strobed on reg_wr.
// A partial write frame whose next byte does not arrive within
// TIMEOUT_CYCLES is discarded and reported on frame_err.
module rx_cmd_decoder
    import smartbench_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data_si,
    input  logic                      rx_rdy_si,
    output logic                      rx_ack_si,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0]     reg_data,
    output logic                      reg_wr,
    output logic [REG_ADDR_WIDTH-1:0] cmd_code,
    output logic                      cmd_strobe,
    output logic                      frame_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    rx_state_t                 state;
    rx_state_t                 state_nxt;
    logic [IDX_W-1:0]          byte_idx;
    logic [REG_ADDR_WIDTH-1:0] addr_buf;
    logic [DATA_WIDTH-1:0]     data_buf;
    logic [DATA_WIDTH-1:0]     data_asm;
    logic                      accept;
    logic                      hdr_is_cmd;
    logic                      last_byte;
    logic                      timer_expire;
    logic                      timeout;

    assign accept     = rx_rdy_si && rx_ack_si;
    assign hdr_is_cmd = is_cmd_header(rx_data_si);
    assign last_byte  = (state == GET_DATA) && (byte_idx == LAST_IDX);
    // A byte accepted on the expiry cycle wins over the timeout.
    assign timeout    = timer_expire && !accept;

    // Inter-byte timer: runs only while collecting payload, restarted by every byte.
    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear ((state != GET_DATA) || accept),
        .enable(state == GET_DATA),
        .expire(timer_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: header dispatch, payload count, timeout abort.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !hdr_is_cmd) begin
                    state_nxt = GET_DATA;
                end
            end
            GET_DATA: begin
                if (accept && last_byte) begin
                    state_nxt = WRITE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: byte handshake and write strobe decoded from state.
    always_comb begin
        // The WRITE cycle is the only handshake gap; reset forces ack low.
        rx_ack_si = rst && rx_rdy_si && (state != WRITE);
        reg_wr    = (state == WRITE);
    end

    // Payload assembly: drop the incoming byte into its little-endian lane.
    always_comb begin
        data_asm = data_buf;
        for (int k = 0; k < NB; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                data_asm[8*k +: 8] = rx_data_si;
            end
        end
    end

    // Datapath: header capture, payload collection, register outputs, pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= '0;
            addr_buf   <= '0;
            data_buf   <= '0;
            reg_addr   <= '0;
            reg_data   <= '0;
            cmd_code   <= '0;
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cmd_strobe <= (state == IDLE) && accept && hdr_is_cmd;
            frame_err  <= (state == GET_DATA) && timeout;

            if ((state == IDLE) && accept) begin
                if (hdr_is_cmd) begin
                    cmd_code <= rx_data_si[REG_ADDR_WIDTH-1:0];
                end else begin
                    addr_buf <= rx_data_si[REG_ADDR_WIDTH-1:0];
                    byte_idx <= '0;
                    data_buf <= '0;
                end
            end

            if ((state == GET_DATA) && accept) begin
                data_buf <= data_asm;
                if (last_byte) begin
                    reg_addr <= addr_buf;
                    reg_data <= data_asm;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Self-checking bench for rx_cmd_decoder (DATA_WIDTH=16, TIMEOUT_CYCLES=16).
// The upstream model raises rx_rdy_si with a byte and drops it the cycle
// after the accepting edge. A table of frames is applied first, followed by
// hand-written sequences for strobe timing, timeout, back-to-back streaming
// and mid-frame reset.
module tb_rx_cmd_decoder;

    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data_si = 8'h00;
    logic          rx_rdy_si = 1'b0;
    logic          rx_ack_si;
    logic [6:0]    reg_addr;
    logic [DW-1:0] reg_data;
    logic          reg_wr;
    logic [6:0]    cmd_code;
    logic          cmd_strobe;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    // Observed strobe history.
    logic [22:0] wr_log[$];
    int          cmd_cnt  = 0;
    int          err_cnt  = 0;
    int          ack_wait = 0;

    rx_cmd_decoder #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data_si(rx_data_si),
        .rx_rdy_si (rx_rdy_si),
        .rx_ack_si (rx_ack_si),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .reg_wr    (reg_wr),
        .cmd_code  (cmd_code),
        .cmd_strobe(cmd_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (reg_wr) wr_log.push_back({reg_addr, reg_data});
            if (cmd_strobe) cmd_cnt++;
            if (frame_err) err_cnt++;
            if (rx_rdy_si && !rx_ack_si) ack_wait++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] last_wr();
        return (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : '1;
    endfunction

    // Wait gap cycles with rdy low, offer a byte, return at edge+1 after accept.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data_si = b;
        rx_rdy_si  = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rx_ack_si) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        rx_rdy_si = 1'b0;
        if (!ok) check("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          nb;
        int          gap;
        int          exp_wr;
        int          exp_cmd;
        int          exp_err;
        logic [6:0]  exp_addr;
        logic [15:0] exp_data;
        logic [6:0]  exp_code;
    } vec_t;

    vec_t vec[9];

    initial begin
        int w0, c0, e0;
        logic [7:0] stream[7];

        vec[0] = '{8'h05, 8'h34, 8'h12, 3, 0,  1, 0, 0, 7'h05, 16'h1234, 7'h00};
        vec[1] = '{8'h83, 8'h00, 8'h00, 1, 0,  0, 1, 0, 7'h05, 16'h1234, 7'h03};
        vec[2] = '{8'h02, 8'h22, 8'h11, 3, 0,  1, 0, 0, 7'h02, 16'h1122, 7'h03};
        vec[3] = '{8'h05, 8'h34, 8'h12, 3, 14, 1, 0, 0, 7'h05, 16'h1234, 7'h03};
        vec[4] = '{8'h0A, 8'h78, 8'h56, 3, 15, 1, 0, 0, 7'h0A, 16'h5678, 7'h03};
        vec[5] = '{8'h7F, 8'hFF, 8'hFF, 3, 0,  1, 0, 0, 7'h7F, 16'hFFFF, 7'h03};
        vec[6] = '{8'hFF, 8'h00, 8'h00, 1, 0,  0, 1, 0, 7'h7F, 16'hFFFF, 7'h7F};
        vec[7] = '{8'h80, 8'h00, 8'h00, 1, 0,  0, 1, 0, 7'h7F, 16'hFFFF, 7'h00};
        vec[8] = '{8'h00, 8'h00, 8'h00, 3, 3,  1, 0, 0, 7'h00, 16'h0000, 7'h00};

        // Reset state, with a byte offered to show ack stays low.
        rx_rdy_si = 1'b1;
        #12;
        check("rst_ack", 32'(rx_ack_si), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_data", 32'(reg_data), 32'd0);
        check("rst_strobes", {29'd0, reg_wr, cmd_strobe, frame_err}, 32'd0);
        check("rst_code", 32'(cmd_code), 32'd0);
        rx_rdy_si = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Table-driven frames.
        for (int i = 0; i < 9; i++) begin
            w0 = wr_log.size();
            c0 = cmd_cnt;
            e0 = err_cnt;
            send_byte(vec[i].b0, 0);
            if (vec[i].nb > 1) send_byte(vec[i].b1, 0);
            if (vec[i].nb > 2) send_byte(vec[i].b2, vec[i].gap);
            idle(4);
            check($sformatf("v%0d_nwr", i), 32'(wr_log.size() - w0), 32'(vec[i].exp_wr));
            check($sformatf("v%0d_ncmd", i), 32'(cmd_cnt - c0), 32'(vec[i].exp_cmd));
            check($sformatf("v%0d_nerr", i), 32'(err_cnt - e0), 32'(vec[i].exp_err));
            check($sformatf("v%0d_addr", i), 32'(reg_addr), 32'(vec[i].exp_addr));
            check($sformatf("v%0d_data", i), 32'(reg_data), 32'(vec[i].exp_data));
            check($sformatf("v%0d_code", i), 32'(cmd_code), 32'(vec[i].exp_code));
        end

        // Strobe timing: reg_wr in the cycle after the final accept edge only.
        send_byte(8'h05, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        @(negedge clk);
        check("t_wr_hi", 32'(reg_wr), 32'd1);
        check("t_wr_word", 32'({reg_addr, reg_data}), 32'({7'h05, 16'h1234}));
        check("t_wr_nocmd", {30'd0, cmd_strobe, frame_err}, 32'd0);
        @(negedge clk);
        check("t_wr_lo", 32'(reg_wr), 32'd0);
        idle(1);
        send_byte(8'h83, 0);
        @(negedge clk);
        check("t_cmd_hi", 32'(cmd_strobe), 32'd1);
        check("t_cmd_code", 32'(cmd_code), 32'h03);
        check("t_cmd_nowr", 32'(reg_wr), 32'd0);
        @(negedge clk);
        check("t_cmd_lo", 32'(cmd_strobe), 32'd0);
        idle(1);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        idle(3);
        check("t_after_cmd_wr", 32'(last_wr()), 32'({7'h02, 16'h55AA}));

        // Timeout: 16 idle cycles after a partial frame abort it.
        w0 = wr_log.size();
        e0 = err_cnt;
        send_byte(8'h05, 0);
        send_byte(8'h34, 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("to_err_early", 32'(frame_err), 32'd0);
        @(negedge clk);
        check("to_err_hi", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("to_err_lo", 32'(frame_err), 32'd0);
        idle(6);
        check("to_nerr", 32'(err_cnt - e0), 32'd1);
        check("to_nwr", 32'(wr_log.size() - w0), 32'd0);
        check("to_hold", 32'({reg_addr, reg_data}), 32'({7'h02, 16'h55AA}));
        send_byte(8'h06, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        idle(3);
        check("to_next_wr", 32'(last_wr()), 32'({7'h06, 16'hABCD}));
        check("to_next_nerr", 32'(err_cnt - e0), 32'd1);

        // Back-to-back with rdy held high; trailing command shows the gap too.
        stream = '{8'h01, 8'h11, 8'h22, 8'h02, 8'h33, 8'h44, 8'h81};
        w0 = wr_log.size();
        c0 = cmd_cnt;
        ack_wait = 0;
        rx_rdy_si = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic ok;
            ok = 1'b0;
            rx_data_si = stream[i];
            for (int j = 0; j < 10 && !ok; j++) begin
                @(negedge clk);
                if (rx_ack_si) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end
            end
            if (!ok) check("b2b_accept", 32'(ok), 32'd1);
        end
        rx_rdy_si = 1'b0;
        idle(3);
        check("b2b_ack_gaps", 32'(ack_wait), 32'd2);
        check("b2b_nwr", 32'(wr_log.size() - w0), 32'd2);
        check("b2b_wr0", 32'(wr_log[w0]), 32'({7'h01, 16'h2211}));
        check("b2b_wr1", 32'(last_wr()), 32'({7'h02, 16'h4433}));
        check("b2b_cmd", 32'(cmd_cnt - c0), 32'd1);
        check("b2b_code", 32'(cmd_code), 32'h01);

        // Reset mid-frame: outputs clear at once, next byte is a header.
        send_byte(8'h05, 0);
        send_byte(8'h34, 0);
        rx_data_si = 8'h99;
        rx_rdy_si  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("mr_addr", 32'(reg_addr), 32'd0);
        check("mr_data", 32'(reg_data), 32'd0);
        check("mr_code", 32'(cmd_code), 32'd0);
        check("mr_ack", 32'(rx_ack_si), 32'd0);
        @(negedge clk);
        check("mr_ack_hold", 32'(rx_ack_si), 32'd0);
        rx_rdy_si = 1'b0;
        rst = 1'b1;
        idle(1);
        w0 = wr_log.size();
        send_byte(8'h07, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        idle(3);
        check("mr_nwr", 32'(wr_log.size() - w0), 32'd1);
        check("mr_wr", 32'(last_wr()), 32'({7'h07, 16'h5678}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
